// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state type and the column/row key-map decode for the keypad entry controller.
package keypad_pkg;

  localparam logic [4:0] KEY_ENTER = 5'b11100;
  localparam logic [4:0] KEY_CLEAR = 5'b11110;
  localparam logic [4:0] KEY_BKSP  = 5'b11000;
  localparam logic [4:0] KEY_NONE  = 5'b11111;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } keypad_state_e;

  // Column 3 is the leftmost keypad column, row 3 the top row.
  function automatic logic [4:0] keyDecode(input logic [3:0] col, input logic [3:0] row);
    logic [4:0] code;
    case ({col, row})
      8'b1000_1000: code = 5'd1;
      8'b0100_1000: code = 5'd2;
      8'b0010_1000: code = 5'd3;
      8'b1000_0100: code = 5'd4;
      8'b0100_0100: code = 5'd5;
      8'b0010_0100: code = 5'd6;
      8'b1000_0010: code = 5'd7;
      8'b0100_0010: code = 5'd8;
      8'b0010_0010: code = 5'd9;
      8'b1000_0001: code = 5'd0;
      8'b0100_0001: code = KEY_ENTER;
      8'b0010_0001: code = KEY_CLEAR;
      8'b0001_0001: code = KEY_BKSP;
      default:      code = KEY_NONE;
    endcase
    return code;
  endfunction

  function automatic logic isDigit(input logic [4:0] code);
    return code <= 5'd9;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Stable-cycle counter: done_o fires on the CYC-th consecutive enabled cycle since the last clear.
module keypad_debounce_cnt #(
  parameter int unsigned CYC = 20000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned CW = $clog2(CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign done_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// 4x4 keypad scan, debounce, decode and four-digit BCD entry register.
// Optional auto-repeat of held digit/backspace keys is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_CYC    = 20000,
  parameter int unsigned REPEAT_CYC = 5000000
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [3:0]  keyCols,
  input  logic [3:0]  keyRows,
  output logic [4:0]  Key,
  output logic        key_valid,
  output logic [15:0] entry_bcd,
  output logic [2:0]  entry_len,
  output logic        entry_commit,
  output logic [15:0] committed_bcd
);

  localparam int unsigned SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  keypad_state_e state_q, state_d;
  logic [3:0]    rowsMeta_q, rowsS_q;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic [SW-1:0] scanCnt_q, scanCnt_d;
  logic [4:0]    key_q, key_d;
  logic          keyValid_q, keyValid_d;
  logic [15:0]   entryBcd_q, entryBcd_d;
  logic [2:0]    entryLen_q, entryLen_d;
  logic [15:0]   committed_q, committed_d;
  logic          commit_q, commit_d;
  logic          debClear, debEn, debDone;
  logic [4:0]    heldCode;

  assign heldCode = keyDecode(col_q, row_q);

  keypad_debounce_cnt #(
    .CYC(DEB_CYC)
  ) uDebounce (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clear_i(debClear),
    .en_i   (debEn),
    .done_o (debDone)
  );

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_CYC + 1);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_CYC - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_CYC / 4 - 1);

  logic [RW-1:0] repCnt_q, repCnt_d;
  logic          repeated_q, repeated_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      repCnt_q   <= '0;
      repeated_q <= 1'b0;
    end else begin
      repCnt_q   <= repCnt_d;
      repeated_q <= repeated_d;
    end
  end
`else
  if (REPEAT_CYC < 4) begin : gNoRepeat
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rowsMeta_q <= '0;
      rowsS_q    <= '0;
    end else begin
      rowsMeta_q <= keyRows;
      rowsS_q    <= rowsMeta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    scanCnt_d  = scanCnt_q;
    key_d      = key_q;
    keyValid_d = 1'b0;
    debClear   = 1'b1;
    debEn      = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    repCnt_d   = '0;
    repeated_d = (state_q == HELD || state_q == RELEASE) ? repeated_q : 1'b0;
`endif
    case (state_q)
      SCAN: begin
        if (scanCnt_q == SCAN_LAST) begin
          scanCnt_d = '0;
          if ($onehot(rowsS_q)) begin
            row_d   = rowsS_q;
            state_d = DEBOUNCE;
          end else begin
            col_d = {col_q[0], col_q[3:1]};
          end
        end else begin
          scanCnt_d = scanCnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (rowsS_q == row_q) begin
          debClear = 1'b0;
          debEn    = 1'b1;
          if (debDone) begin
            state_d = HELD;
            if (heldCode != KEY_NONE) begin
              key_d      = heldCode;
              keyValid_d = 1'b1;
            end
          end
        end else begin
          state_d = SCAN;
          col_d   = {col_q[0], col_q[3:1]};
        end
      end
      HELD: begin
        if (rowsS_q == 4'b0000) begin
          state_d = RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rowsS_q == row_q && (isDigit(heldCode) || heldCode == KEY_BKSP)) begin
          if (repCnt_q == (repeated_q ? REP_NEXT : REP_FIRST)) begin
            key_d      = heldCode;
            keyValid_d = 1'b1;
            repeated_d = 1'b1;
          end else begin
            repCnt_d = repCnt_q + 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        if (rowsS_q == 4'b0000) begin
          debClear = 1'b0;
          debEn    = 1'b1;
          if (debDone) begin
            state_d = SCAN;
            col_d   = {col_q[0], col_q[3:1]};
          end
        end else begin
          state_d = HELD;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Entry edits act on the registered key pulse, so they land one cycle after key_valid.
  always_comb begin
    entryBcd_d  = entryBcd_q;
    entryLen_d  = entryLen_q;
    committed_d = committed_q;
    commit_d    = 1'b0;
    if (keyValid_q) begin
      if (isDigit(key_q)) begin
        if (entryLen_q != 3'd4) begin
          entryBcd_d = {entryBcd_q[11:0], key_q[3:0]};
          entryLen_d = entryLen_q + 3'd1;
        end
      end else begin
        case (key_q)
          KEY_BKSP: begin
            if (entryLen_q != 3'd0) begin
              entryBcd_d = {4'h0, entryBcd_q[15:4]};
              entryLen_d = entryLen_q - 3'd1;
            end
          end
          KEY_CLEAR: begin
            entryBcd_d = '0;
            entryLen_d = '0;
          end
          KEY_ENTER: begin
            committed_d = entryBcd_q;
            commit_d    = 1'b1;
            entryBcd_d  = '0;
            entryLen_d  = '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= SCAN;
      col_q       <= 4'b1000;
      row_q       <= '0;
      scanCnt_q   <= '0;
      key_q       <= KEY_NONE;
      keyValid_q  <= 1'b0;
      entryBcd_q  <= '0;
      entryLen_q  <= '0;
      committed_q <= '0;
      commit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      scanCnt_q   <= scanCnt_d;
      key_q       <= key_d;
      keyValid_q  <= keyValid_d;
      entryBcd_q  <= entryBcd_d;
      entryLen_q  <= entryLen_d;
      committed_q <= committed_d;
      commit_q    <= commit_d;
    end
  end

  assign keyCols       = col_q;
  assign Key           = key_q;
  assign key_valid     = keyValid_q;
  assign entry_bcd     = entryBcd_q;
  assign entry_len     = entryLen_q;
  assign entry_commit  = commit_q;
  assign committed_bcd = committed_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl: a small keypad model drives rows only while the pressed key's column is driven.
module tb_keypad_entry_ctrl;

  localparam int SCAN_DIV = 8;
  localparam int DEB_CYC  = 40;
  localparam int BUDGET   = 4 * SCAN_DIV + DEB_CYC + 40;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  keyCols;
  logic [3:0]  keyRows;
  logic [4:0]  Key;
  logic        key_valid;
  logic [15:0] entry_bcd;
  logic [2:0]  entry_len;
  logic        entry_commit;
  logic [15:0] committed_bcd;

  logic [3:0] pressCol = 4'b0000;
  logic [3:0] pressRow = 4'b0000;
  logic       bounceOff = 1'b0;
  int checks = 0;
  int errors = 0;
  int validCount = 0;
  int commitCount = 0;

  keypad_entry_ctrl #(
    .SCAN_DIV  (SCAN_DIV),
    .DEB_CYC   (DEB_CYC),
    .REPEAT_CYC(400)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .keyCols      (keyCols),
    .keyRows      (keyRows),
    .Key          (Key),
    .key_valid    (key_valid),
    .entry_bcd    (entry_bcd),
    .entry_len    (entry_len),
    .entry_commit (entry_commit),
    .committed_bcd(committed_bcd)
  );

  always #5 CLK = ~CLK;

  assign keyRows = ((|(keyCols & pressCol)) && !bounceOff) ? pressRow : 4'b0000;

  always @(posedge CLK) begin
    if (key_valid)    validCount  <= validCount + 1;
    if (entry_commit) commitCount <= commitCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] col, input logic [3:0] row);
    pressCol = col;
    pressRow = row;
  endtask

  task automatic releaseKey();
    applyStimulus(4'b0000, 4'b0000);
    repeat (DEB_CYC + 20) @(negedge CLK);
  endtask

  task automatic waitValid(input string tag);
    int n = 0;
    while (key_valid !== 1'b1 && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    checkOutput({tag, " key_valid"}, 32'(key_valid), 32'd1);
  endtask

  task automatic typeKey(input string tag, input logic [3:0] col, input logic [3:0] row, input logic [4:0] code);
    int v0 = validCount;
    applyStimulus(col, row);
    waitValid(tag);
    checkOutput({tag, " Key"}, 32'(Key), 32'(code));
    repeat (20) @(negedge CLK);
    releaseKey();
    checkOutput({tag, " pulses"}, 32'(validCount - v0), 32'd1);
  endtask

  task automatic checkEntry(input string tag, input logic [15:0] bcd, input logic [2:0] len);
    checkOutput({tag, " entry_bcd"}, 32'(entry_bcd), 32'(bcd));
    checkOutput({tag, " entry_len"}, 32'(entry_len), 32'(len));
  endtask

  initial begin
    int v0;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("rst keyCols", 32'(keyCols), 32'h8);
    checkOutput("rst Key", 32'(Key), 32'h1f);
    checkOutput("rst key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst entry_commit", 32'(entry_commit), 32'd0);
    checkOutput("rst committed", 32'(committed_bcd), 32'd0);
    checkEntry("rst", 16'h0000, 3'd0);
    RST_N = 1'b1;

    repeat (4) @(negedge CLK);
    checkOutput("scan col3", 32'(keyCols), 32'h8);
    repeat (4) @(negedge CLK);
    checkOutput("scan col2", 32'(keyCols), 32'h4);
    repeat (8) @(negedge CLK);
    checkOutput("scan col1", 32'(keyCols), 32'h2);
    repeat (8) @(negedge CLK);
    checkOutput("scan col0", 32'(keyCols), 32'h1);
    repeat (8) @(negedge CLK);
    checkOutput("scan wrap", 32'(keyCols), 32'h8);
    checkOutput("scan Key", 32'(Key), 32'h1f);
    checkOutput("scan len", 32'(entry_len), 32'd0);

    typeKey("key5", 4'b0100, 4'b0100, 5'd5);
    checkEntry("key5", 16'h0005, 3'd1);

    v0 = validCount;
    applyStimulus(4'b0010, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      bounceOff = (i == 1);
      repeat (10) @(negedge CLK);
    end
    bounceOff = 1'b0;
    checkOutput("bounce no pulse", 32'(validCount - v0), 32'd0);
    waitValid("bounce");
    checkOutput("bounce Key", 32'(Key), 32'd3);
    repeat (20) @(negedge CLK);
    releaseKey();
    checkOutput("bounce pulses", 32'(validCount - v0), 32'd1);
    checkEntry("bounce", 16'h0053, 3'd2);

    typeKey("clr1", 4'b0010, 4'b0001, 5'b11110);
    checkEntry("clr1", 16'h0000, 3'd0);
    typeKey("k1", 4'b1000, 4'b1000, 5'd1);
    typeKey("k2", 4'b0100, 4'b1000, 5'd2);
    typeKey("k3", 4'b0010, 4'b1000, 5'd3);
    typeKey("k4", 4'b1000, 4'b0100, 5'd4);
    checkEntry("four digits", 16'h1234, 3'd4);
    typeKey("k5 full", 4'b0100, 4'b0100, 5'd5);
    checkEntry("full drop", 16'h1234, 3'd4);

    applyStimulus(4'b0100, 4'b0001);
    waitValid("enter");
    checkOutput("enter Key", 32'(Key), 32'h1c);
    checkOutput("enter commit early", 32'(entry_commit), 32'd0);
    checkOutput("enter committed early", 32'(committed_bcd), 32'h0000);
    @(negedge CLK);
    checkOutput("enter commit", 32'(entry_commit), 32'd1);
    checkOutput("enter committed", 32'(committed_bcd), 32'h1234);
    checkEntry("enter cleared", 16'h0000, 3'd0);
    repeat (20) @(negedge CLK);
    releaseKey();
    checkOutput("enter commit count", 32'(commitCount), 32'd1);

    typeKey("enter empty", 4'b0100, 4'b0001, 5'b11100);
    checkOutput("empty committed", 32'(committed_bcd), 32'h0000);
    checkOutput("empty commit count", 32'(commitCount), 32'd2);

    typeKey("k7", 4'b1000, 4'b0010, 5'd7);
    typeKey("k8", 4'b0100, 4'b0010, 5'd8);
    checkEntry("78", 16'h0078, 3'd2);
    typeKey("bksp", 4'b0001, 4'b0001, 5'b11000);
    checkEntry("bksp", 16'h0007, 3'd1);
    typeKey("clr2", 4'b0010, 4'b0001, 5'b11110);
    checkEntry("clr2", 16'h0000, 3'd0);
    typeKey("bksp0", 4'b0001, 4'b0001, 5'b11000);
    checkEntry("bksp0", 16'h0000, 3'd0);

    typeKey("k7b", 4'b1000, 4'b0010, 5'd7);
    typeKey("enter7", 4'b0100, 4'b0001, 5'b11100);
    checkOutput("committed 7", 32'(committed_bcd), 32'h0007);
    typeKey("k8b", 4'b0100, 4'b0010, 5'd8);
    checkEntry("pre reset", 16'h0008, 3'd1);

    v0 = validCount;
    applyStimulus(4'b0010, 4'b0010);
    repeat (36) @(negedge CLK);
    checkOutput("debounce no pulse", 32'(validCount - v0), 32'd0);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    checkOutput("midrst keyCols", 32'(keyCols), 32'h8);
    checkOutput("midrst Key", 32'(Key), 32'h1f);
    checkOutput("midrst key_valid", 32'(key_valid), 32'd0);
    checkOutput("midrst committed", 32'(committed_bcd), 32'd0);
    checkEntry("midrst", 16'h0000, 3'd0);
    RST_N = 1'b1;
    v0 = validCount;
    repeat (DEB_CYC) @(negedge CLK);
    checkOutput("reacquire not early", 32'(validCount - v0), 32'd0);
    waitValid("reacquire");
    checkOutput("reacquire Key", 32'(Key), 32'd9);
    repeat (20) @(negedge CLK);
    releaseKey();
    checkOutput("reacquire pulses", 32'(validCount - v0), 32'd1);
    checkEntry("reacquire", 16'h0009, 3'd1);

    v0 = validCount;
    applyStimulus(4'b1000, 4'b1100);
    repeat (2 * BUDGET) @(negedge CLK);
    releaseKey();
    checkOutput("two rows no pulse", 32'(validCount - v0), 32'd0);
    checkEntry("two rows", 16'h0009, 3'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
# keypad_entry_ctrl

- Sequencing controller for the 4x4 matrix keypad:
  - drives the one-hot column scan and samples the rows through a synchroniser;
  - debounces press and release, and decodes one key code per press;
  - assembles up to four BCD digits into an entry register, with enter, clear and backspace commands.
- Sits between the keypad pins and the display/application logic.
- Replaces the free-running sweep-and-decode path with a single clocked, reset-defined block.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before advancing (≥4)
- DEB_CYC, 20000: consecutive stable cycles required to accept a press or a release (≥2)
- REPEAT_CYC, 5000000: hold time before auto-repeat (used only with KEYPAD_AUTOREPEAT_EN)

Ports:
- CLK  in  1  single system clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- keyCols  out  4  one-hot column drive, active-high
- keyRows  in  4  raw row inputs, active-high, asynchronous
- Key  out  5  last accepted key code
- key_valid  out  1  one-cycle pulse when Key updates
- entry_bcd  out  16  digits being entered; newest digit in [3:0]
- entry_len  out  3  digits held, 0..4
- entry_commit  out  1  one-cycle pulse on enter
- committed_bcd  out  16  value captured on last enter

## Operation
- Key map (col bit, row bit → code):
  - row3: col3=1, col2=2, col1=3
  - row2: col3=4, col2=5, col1=6
  - row1: col3=7, col2=8, col1=9
  - row0: col3=0, col2=5'b11100 ENTER, col1=5'b11110 CLEAR, col0=5'b11000 BKSP
  - any other combination = 5'b11111, ignored
- rows_s is keyRows after a 2-flop synchroniser.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
  - SCAN:
    - drive col one-hot; rotate 3→2→1→0→3 every SCAN_DIV cycles;
    - on the last slot cycle, if rows_s is exactly one-hot, latch col/row and go DEBOUNCE, keeping that column driven;
    - zero or multiple rows: keep scanning.
  - DEBOUNCE:
    - count while rows_s equals the latched row;
    - any mismatch → SCAN, resuming at the next column;
    - count reaches DEB_CYC → decode;
    - valid code: Key=code and key_valid=1 for one cycle, then HELD;
    - code 11111: go to HELD, no pulse.
  - HELD: column stays driven; rows_s==0 → RELEASE.
  - RELEASE:
    - count cycles with rows_s==0; any nonzero row → HELD;
    - DEB_CYC reached → SCAN at the next column.
- Entry update, applied the cycle after key_valid:
  - digit with entry_len<4: entry_bcd={entry_bcd[11:0],digit}, entry_len+1;
  - digit with entry_len==4: ignored.
  - BKSP: entry_bcd={4'h0,entry_bcd[15:4]}, entry_len−1; no-op at 0.
  - CLEAR: entry_bcd=0, entry_len=0.
  - ENTER:
    - committed_bcd=entry_bcd and entry_commit=1, then entry cleared;
    - ENTER with entry_len==0 still pulses and commits 0.
- Reset values: keyCols=4'b1000, Key=5'b11111, key_valid=0, entry_bcd=0, entry_len=0, entry_commit=0, committed_bcd=0.
  - FSM=SCAN, counters=0, synchroniser=0.
  - Reset mid-press: the press is discarded; a key still held after reset is re-acquired through the full debounce.

## Timing
- Press latency:
  - synchroniser: 2 cycles;
  - detection: ≤4·SCAN_DIV cycles to reach the slot end;
  - acceptance: DEB_CYC cycles to key_valid.
- entry_bcd, entry_len, committed_bcd and entry_commit change exactly 1 cycle after key_valid.
- At most one key_valid per press (without auto-repeat); minimum spacing ≥ 2·DEB_CYC cycles.
- keyCols changes only on slot boundaries in SCAN, and is constant in DEBOUNCE, HELD and RELEASE.

## Configuration
- KEYPAD_AUTOREPEAT_EN defined:
  - in HELD, with rows_s unchanged, re-emit key_valid with the same Key after REPEAT_CYC cycles, then every REPEAT_CYC/4 cycles;
  - repeat applies to digits and BKSP only, never to ENTER or CLEAR.
- KEYPAD_AUTOREPEAT_EN undefined: the repeat counter is absent; exactly one pulse per press.

## Structure
- Package keypad_pkg holds:
  - the key-code constants KEY_ENTER, KEY_CLEAR, KEY_BKSP, KEY_NONE;
  - the FSM state enum;
  - the decode function from {col,row} to code.
- One sub-module, keypad_debounce_cnt: a parameterised stable-cycle counter with clear and done, shared by DEBOUNCE and RELEASE.

## Test plan
- Reset, no input → keyCols 1000,0100,0010,0001 rotating every SCAN_DIV cycles; Key=5'b11111; entry_len=0.
- Press col2/row2 clean, hold for >DEB_CYC+4·SCAN_DIV cycles → single key_valid with Key=5; entry_bcd=16'h0005, entry_len=1.
- Press with bounce (row toggling every 10 cycles for 3·DEB_CYC/4) then stable → exactly one key_valid after the stable window; no pulse during the bounce.
- Keys 1,2,3,4,5 then ENTER → entry_bcd=16'h1234 (the 5 is dropped); committed_bcd=16'h1234; entry_commit pulses once; entry_len=0.
- Keys 7,8 then BKSP, then CLEAR → 16'h0078 → 16'h0007 (len 1) → 0 (len 0); BKSP at len 0 leaves state unchanged.
- Reset asserted in DEBOUNCE while key held → outputs return to reset values; after release, one key_valid follows the re-press; rows 1000 and 0100 pressed together → no key_valid.
